// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial bit-pattern detector.
// A runtime-loaded pattern (1..MAX_LEN bits) is compared against a sliding
// window of the most recent accepted bits; a hit produces a registered
// one-cycle match pulse. Overlapping or non-overlapping detection is
// selected at load time.
// Optional feature: define SEQ_DET_CNT_EN to build the saturating match
// counter; without it match_cnt is tied to zero and no counter flops exist.
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt
);

    // Active configuration, captured only on cfg_load
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;

    // Detection state: shift history of accepted bits and how many of them
    // are still eligible to form a match
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;

    // Values the state would take if the current bit is accepted
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               len_ok;
    logic               hit;

    assign hist_next = {hist_q[MAX_LEN-2:0], in_bit};

    // fill saturates at MAX_LEN so a long run of bits never wraps it
    assign fill_next = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                   : fill_q + LEN_W'(1);

    // Only the low len bits of the window take part in the compare
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // len=0 and len>MAX_LEN are treated as "detector disabled"
    assign len_ok = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));

    assign hit = len_ok && (fill_next >= len_q)
                 && (((hist_next ^ pattern_q) & len_mask) == '0);

    // Next-state: cfg_load wins over a same-cycle valid bit, idle cycles hold
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            hist_d  = hist_next;
            fill_d  = (hit && !overlap_q) ? '0 : fill_next;
            match_d = hit;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter steps with each hit and sticks at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (in_valid && hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register shares the detector's reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed scoreboard bench for seq_det_prog.
// Expected match/count values are queued as each stimulus cycle is driven
// and popped when the registered outputs are sampled 1ns after the edge.
// A 2-bit counter is used so saturation is reached quickly.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               rstn;
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    typedef struct {
        logic  m;
        int    c;
        string tag;
    } exp_t;

    exp_t sbQueue[$];
    int   vectorCount = 0;
    int   errorCount  = 0;

    seq_det_prog #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .match       (match),
        .match_cnt   (match_cnt)
    );

    // 10ns free-running clock
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the sampled outputs
    task automatic checkOutput();
        exp_t             e;
        logic [CNT_W-1:0] expCnt;
        if (sbQueue.size() == 0) begin
            vectorCount++;
            errorCount++;
            $error("[TB] FAIL scoreboard: queue empty, observed match %b cnt %0d", match, match_cnt);
            return;
        end
        e = sbQueue.pop_front();
`ifdef SEQ_DET_CNT_EN
        expCnt = CNT_W'(e.c);
`else
        expCnt = '0;
`endif
        vectorCount++;
        assert (match === e.m) else begin
            errorCount++;
            $error("[TB] FAIL %s match: observed %b expected %b", e.tag, match, e.m);
        end
        vectorCount++;
        assert (match_cnt === expCnt) else begin
            errorCount++;
            $error("[TB] FAIL %s match_cnt: observed %0d expected %0d", e.tag, match_cnt, expCnt);
        end
    endtask

    // One data cycle: drive, queue the expectation, clock, sample
    task automatic applyStimulus(input logic v, input logic b, input logic expM,
                                 input int expC, input string tag);
        in_valid = v;
        in_bit   = b;
        cfg_load = 1'b0;
        sbQueue.push_back('{expM, expC, tag});
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Load cycle; cfg inputs are scrambled afterwards so any later sampling shows up
    task automatic loadCfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov, input logic v, input logic b, input string tag);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = v;
        in_bit      = b;
        sbQueue.push_back('{1'b0, 0, tag});
        @(posedge clk);
        #1;
        cfg_load    = 1'b0;
        cfg_pattern = '1;
        cfg_len     = LEN_W'(1);
        cfg_overlap = ~ov;
        in_valid    = 1'b0;
        checkOutput();
    endtask

    // Directed sequence following the detector's test plan
    initial begin
        rstn        = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        #1;
        sbQueue.push_back('{1'b0, 0, "reset"});
        checkOutput();
        #11;
        rstn = 1'b1;

        // Before any load the detector is idle, even though pattern 0 would fit
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, "idle");

        // Overlapping 1011 detection
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b1, 1'b0, 1'b0, "loadOvl");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "ovl1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "ovl2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "ovl3");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "ovl4");
        applyStimulus(1'b1, 1'b0, 1'b0, 1, "ovl5");
        applyStimulus(1'b1, 1'b1, 1'b0, 1, "ovl6");
        applyStimulus(1'b1, 1'b1, 1'b1, 2, "ovl7");

        // Non-overlapping: the trailing 1 of the first match is not reused
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b0, 1'b0, 1'b0, "loadNov");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "nov1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "nov2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "nov3");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "nov4");
        applyStimulus(1'b1, 1'b0, 1'b0, 1, "nov5");
        applyStimulus(1'b1, 1'b1, 1'b0, 1, "nov6");
        applyStimulus(1'b1, 1'b1, 1'b0, 1, "nov7");

        // Valid gaps are transparent; in_bit toggles during gaps to prove it is ignored
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b1, 1'b0, 1'b0, "loadGap");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "gapBit1");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, i[0], 1'b0, 0, "gapA");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "gapBit2");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, ~i[0], 1'b0, 0, "gapB");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "gapBit3");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, i[0], 1'b0, 0, "gapC");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "gapBit4");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1, "gapAfter");

        // Reload mid-stream with a same-cycle valid bit that must be dropped
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b1, 1'b0, 1'b0, "loadRel");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rel1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "rel2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rel3");
        loadCfg(8'b0000_0011, LEN_W'(2), 1'b1, 1'b1, 1'b1, "reload");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "relAfter1");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "relAfter2");

        // Reset mid-stream clears history, config and outputs
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b1, 1'b0, 1'b0, "loadRst");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rst1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "rst2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rst3");
        rstn = 1'b0;
        #1;
        sbQueue.push_back('{1'b0, 0, "rstAsync"});
        checkOutput();
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rstHeld");
        rstn = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rstIdle1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "rstIdle2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rstIdle3");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "rstIdle4");
        loadCfg(8'b0000_1011, LEN_W'(4), 1'b1, 1'b0, 1'b0, "loadPostRst");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "post1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "post2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "post3");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "post4");

        // len=1 pattern=1: every 1 matches, counter saturates at 3
        loadCfg(8'b0000_0001, LEN_W'(1), 1'b1, 1'b0, 1'b0, "loadSat");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "sat1");
        applyStimulus(1'b1, 1'b1, 1'b1, 2, "sat2");
        applyStimulus(1'b1, 1'b1, 1'b1, 3, "sat3");
        applyStimulus(1'b1, 1'b1, 1'b1, 3, "sat4");
        applyStimulus(1'b1, 1'b1, 1'b1, 3, "sat5");
        applyStimulus(1'b1, 1'b1, 1'b1, 3, "sat6");

        // len=0 never matches
        loadCfg(8'b0000_0000, LEN_W'(0), 1'b1, 1'b0, 1'b0, "loadLen0");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len0a");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "len0b");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len0c");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len0d");

        // Full-length pattern 10100101
        loadCfg(8'b1010_0101, LEN_W'(8), 1'b0, 1'b0, 1'b0, "loadLen8");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "len8b1");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len8b2");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "len8b3");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len8b4");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len8b5");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, "len8b6");
        applyStimulus(1'b1, 1'b0, 1'b0, 0, "len8b7");
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "len8b8");

        // len beyond MAX_LEN never matches, even with a long run of zeros
        loadCfg(8'b0000_0000, LEN_W'(9), 1'b1, 1'b0, 1'b0, "loadLen9");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, "len9");

        if (sbQueue.size() != 0) begin
            vectorCount++;
            errorCount++;
            $error("[TB] FAIL scoreboard drain: observed %0d left expected 0", sbQueue.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
